// File: rtl/i2s_capture_seq.sv
`default_nettype none
// ============================================================================
// Module      : i2s_capture_seq
// Description : Runs one I2S capture session. It enables the receiver, flushes
//               the FIFO, optionally waits for the averaging trigger, and then
//               drains N samples into a valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_capture_seq #(
    parameter int DW = 32,
    parameter int CW = 16,
    parameter int TW = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic [CW-1:0] cfg_count,
    input  logic          cfg_trig_avg,
    input  logic [TW-1:0] cfg_timeout,
    output logic          i2s_en,
    output logic          fifo_flush,
    output logic          fifo_rd,
    input  logic          fifo_empty,
    input  logic          fifo_full,
    input  logic [DW-1:0] fifo_rdata,
    input  logic          avg_flag,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy,
    output logic          done,
    output logic [1:0]    status,
    output logic          overrun
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_FLUSH   = 3'd1;
    localparam logic [2:0] c_ARM     = 3'd2;
    localparam logic [2:0] c_CAPTURE = 3'd3;
    localparam logic [2:0] c_DRAIN   = 3'd4;
    localparam logic [2:0] c_DONE    = 3'd5;

    localparam logic [1:0] c_ST_OK      = 2'b00;
    localparam logic [1:0] c_ST_TIMEOUT = 2'b01;
    localparam logic [1:0] c_ST_ABORT   = 2'b10;

    logic [2:0]    r_state;
    logic [2:0]    w_next;

    logic [CW-1:0] r_cnt;
    logic          r_trig;
    logic [TW-1:0] r_tmo;
    logic [CW-1:0] r_words;
    logic [TW-1:0] r_tcnt;

    logic          r_out_valid;
    logic [DW-1:0] r_out_data;
    logic          r_out_last;
    logic [1:0]    r_status;
    logic          r_overrun;

    logic          w_start_ok;
    logic          w_active;
    logic          w_rd;
    logic [CW:0]   w_words_inc;
    logic          w_last_pop;
    logic          w_trig_hit;
    logic          w_tmo_hit;

    assign w_start_ok  = (r_state == c_IDLE) && start && !stop;
    assign w_active    = (r_state == c_FLUSH) || (r_state == c_ARM) || (r_state == c_CAPTURE);
    assign w_rd        = (r_state == c_CAPTURE) && !fifo_empty
                         && (!r_out_valid || out_ready) && (r_words < r_cnt);
    assign w_words_inc = {1'b0, r_words} + (CW+1)'(1);
    assign w_last_pop  = w_rd && (w_words_inc == {1'b0, r_cnt});
    assign w_trig_hit  = !r_trig || avg_flag;
    // Timeout counter starts at 0 on the first ARM cycle, so ARM lasts cfg_timeout cycles.
    assign w_tmo_hit   = (r_tmo != '0) && (r_tcnt == (r_tmo - TW'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_start_ok) begin
                    w_next = (cfg_count != '0) ? c_FLUSH : c_DONE;
                end
            end
            c_FLUSH: begin
                w_next = stop ? c_DRAIN : c_ARM;
            end
            c_ARM: begin
                if (stop) begin
                    w_next = c_DRAIN;
                end else if (w_trig_hit) begin
                    w_next = c_CAPTURE;
                end else if (w_tmo_hit) begin
                    w_next = c_DRAIN;
                end
            end
            c_CAPTURE: begin
                if (stop || w_last_pop) begin
                    w_next = c_DRAIN;
                end
            end
            c_DRAIN: begin
                if (!r_out_valid || out_ready) begin
                    w_next = c_DONE;
                end
            end
            c_DONE: begin
                w_next = c_IDLE;
            end
            default: begin
                w_next = c_IDLE;
            end
        endcase
    end

    always_comb begin
        i2s_en     = w_active;
        fifo_flush = (r_state == c_FLUSH);
        fifo_rd    = w_rd;
        busy       = (r_state != c_IDLE);
        done       = (r_state == c_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_trig  <= 1'b0;
            r_tmo   <= '0;
            r_words <= '0;
            r_tcnt  <= '0;
        end else begin
            if (w_start_ok) begin
                r_cnt   <= cfg_count;
                r_trig  <= cfg_trig_avg;
                r_tmo   <= cfg_timeout;
                r_words <= '0;
                r_tcnt  <= '0;
            end else begin
                if (w_rd) begin
                    r_words <= r_words + CW'(1);
                end
                if ((r_state == c_ARM) && (r_tcnt != '1)) begin
                    r_tcnt <= r_tcnt + TW'(1);
                end
            end
        end
    end

    // Single-stage output register: a load may coincide with the accept of the previous word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else if (w_rd) begin
            r_out_valid <= 1'b1;
            r_out_data  <= fifo_rdata;
            r_out_last  <= w_last_pop;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_status  <= c_ST_OK;
            r_overrun <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_status <= c_ST_OK;
            end else if (w_active && stop) begin
                r_status <= c_ST_ABORT;
            end else if ((r_state == c_ARM) && !w_trig_hit && w_tmo_hit) begin
                r_status <= c_ST_TIMEOUT;
            end

            if (w_start_ok) begin
                r_overrun <= 1'b0;
            end else if (((r_state == c_ARM) || (r_state == c_CAPTURE)) && fifo_full) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign status    = r_status;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire
